// File: rtl/fifo_no_reset_data.sv
// fifo_no_reset_data: single-clock FWFT valid/ready FIFO; only pointers and count are reset, storage is not
module fifo_no_reset_data #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_input_valid,
    output logic             o_input_ready,
    input  logic [WIDTH-1:0] i_input_data,
    output logic             o_output_valid,
    input  logic             i_output_ready,
    output logic [WIDTH-1:0] o_output_data
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0] count;
    logic push;
    logic pop;
    assign o_input_ready = count != (AW+1)'(DEPTH);
    assign o_output_valid = count != '0;
    assign o_output_data = mem[rd_ptr];
    assign push = i_input_valid & o_input_ready;
    assign pop = o_output_valid & i_output_ready;
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_input_data;
    end
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_fifo_no_reset_data.sv
// tb_fifo_no_reset_data: directed and randomized-stall checks of fifo_no_reset_data against a queue model
module tb_fifo_no_reset_data;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    logic i_clk = 0;
    logic i_reset = 0;
    logic i_input_valid = 0;
    logic o_input_ready;
    logic [WIDTH-1:0] i_input_data = '0;
    logic o_output_valid;
    logic i_output_ready = 0;
    logic [WIDTH-1:0] o_output_data;
    int n_checks = 0;
    int n_fail = 0;
    logic [WIDTH-1:0] q[$];
    string phase = "reset";

    fifo_no_reset_data #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_input_valid(i_input_valid),
        .o_input_ready(o_input_ready),
        .i_input_data(i_input_data),
        .o_output_valid(o_output_valid),
        .i_output_ready(i_output_ready),
        .o_output_data(o_output_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    // Check flags/head against the model, then take one clock edge and update the model.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r);
        bit push;
        bit pop;
        i_input_valid = v;
        i_input_data = d;
        i_output_ready = r;
        check("ready", o_input_ready, q.size() != DEPTH);
        check("valid", o_output_valid, q.size() != 0);
        if (q.size() != 0) check("data", o_output_data, q[0]);
        push = v && q.size() != DEPTH;
        pop = r && q.size() != 0;
        @(posedge i_clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(d);
    endtask

    initial begin
        int pushes;
        int guard;
        repeat (2) @(posedge i_clk);
        #1;
        check("ready_in_reset", o_input_ready, 1);
        check("valid_in_reset", o_output_valid, 0);
        i_reset = 1;

        phase = "fill";
        for (int i = 0; i < DEPTH; i++) cycle(1, i, 0);
        check("full_ready", o_input_ready, 0);
        check("full_head", o_output_data, 0);
        cycle(1, 32'h99, 0);
        check("no_push_when_full", q.size(), DEPTH);

        phase = "stream";
        for (int j = 0; j < 128; j++) cycle(1, j, 1);

        phase = "drain";
        while (q.size() != 0) cycle(0, 0, 1);
        check("drained_valid", o_output_valid, 0);
        check("drained_ready", o_input_ready, 1);

        phase = "empty_push";
        cycle(1, 32'hA5A5A5A5, 1);
        check("valid_after_1", o_output_valid, 1);
        check("data_after_1", o_output_data, 32'hA5A5A5A5);
        cycle(0, 0, 1);
        check("empty_again", o_output_valid, 0);

        phase = "mid_reset";
        for (int i = 0; i < 10; i++) cycle(1, 32'h100 + i, 0);
        i_input_valid = 0;
        #2;
        i_reset = 0;
        #1;
        check("ready_async", o_input_ready, 1);
        check("valid_async", o_output_valid, 0);
        q.delete();
        @(posedge i_clk);
        #1;
        i_reset = 1;
        cycle(1, 32'h1234, 0);
        check("first_after_reset", o_output_data, 32'h1234);
        cycle(0, 0, 1);

        phase = "wrap";
        pushes = 0;
        guard = 0;
        while (pushes < 3 * DEPTH && guard < 4000) begin
            logic v;
            logic r;
            v = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 3) != 0;
            if (v && q.size() != DEPTH) pushes++;
            cycle(v, $urandom, r);
            guard++;
        end
        check("wrap_budget", guard < 4000, 1);
        while (q.size() != 0) cycle(0, 0, 1);
        check("wrap_end_valid", o_output_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
